force_writeback_ctrl: RTL and testbench

- Consumes the 128-bit force result stream produced by the long-range electrostatics pipeline. Each word carries three 32-bit fixed-point components, Fx[31:0], Fy[63:32] and Fz[95:64], with [127:96] zero.
- Buffers the stream in a small FIFO, programs the host-memory write master, and streams the words into its user write buffer.
- Sits at the opposite end of the particle datapath from the read master that feeds user_buffer_data.

---
 rtl/force_writeback_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_force_writeback_ctrl.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/force_writeback_ctrl.sv
// force_writeback_ctrl: drains the electrostatics force-result stream into the
// host-memory write master. The stream has no backpressure. Words are
// skid-buffered in a small FIFO, the write master is programmed once per pass,
// and the words are pushed into the master's user write buffer.
//
// Optional build macro: FORCE_WB_TRAILER_EN
//   When defined, one status trailer word is appended after the last force word
//   of every pass. The write master length includes the trailer.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start; force words are ignored
// PROGRAM   | control_go pulse with base/length; FIFO already accepting
// STREAM    | popping FIFO into the write master buffer
// WAIT_DONE | all words (and trailer) pushed; waiting for control_done
// DONE      | emit the done pulse, then return to IDLE

module force_writeback_ctrl #(
  parameter int DATA_WIDTH      = 128,
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int COUNT_WIDTH     = 16,
  parameter int BYTES_PER_WORD  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] num_particles,
  input  logic                   force_valid,
  input  logic [DATA_WIDTH-1:0]  force_data,
  output logic                   control_fixed_location,
  output logic [ADDR_WIDTH-1:0]  control_base,
  output logic [ADDR_WIDTH-1:0]  control_length,
  output logic                   control_go,
  input  logic                   control_done,
  output logic                   user_write_buffer,
  output logic [DATA_WIDTH-1:0]  user_buffer_output_data,
  input  logic                   user_buffer_full,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow_err,
  output logic [COUNT_WIDTH-1:0] words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROGRAM,
    S_STREAM,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  localparam logic [FIFO_ADDR_WIDTH:0] FIFO_FULL_CNT = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [FIFO_ADDR_WIDTH:0] FIFO_ONE      = (FIFO_ADDR_WIDTH+1)'(1);
  localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE     = FIFO_ADDR_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE         = COUNT_WIDTH'(1);

  state_t                     state;
  logic [COUNT_WIDTH-1:0]     num_lat;
  logic [COUNT_WIDTH-1:0]     accepted_cnt;
  logic [DATA_WIDTH-1:0]      fifo_mem [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   fifo_cnt;

  logic                  accept_state;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  in_ok;
  logic                  word_pop;
  logic                  accept;
  logic                  drop;
  logic                  fifo_write;
  logic                  fifo_read;
  logic [DATA_WIDTH-1:0] pop_data;

  assign control_fixed_location = 1'b0;

  assign accept_state = (state == S_PROGRAM) || (state == S_STREAM) || (state == S_WAIT_DONE);
  assign fifo_empty   = (fifo_cnt == '0);
  assign fifo_full    = (fifo_cnt == FIFO_FULL_CNT);
  // A word is eligible while the pass still has quota left.
  assign in_ok        = force_valid && accept_state && (accepted_cnt != num_lat);
  // An empty FIFO is bypassed so a word can reach the write buffer one cycle after arrival.
  assign word_pop     = (state == S_STREAM) && !user_buffer_full && (!fifo_empty || in_ok);
  // Full and empty are exclusive, so a pop that frees a slot can be taken here without a loop.
  assign accept       = in_ok && (!fifo_full || word_pop);
  assign drop         = force_valid && accept_state && !accept;
  assign fifo_write   = accept && !(word_pop && fifo_empty);
  assign fifo_read    = word_pop && !fifo_empty;
  assign pop_data     = fifo_empty ? force_data : fifo_mem[rd_ptr];

`ifdef FORCE_WB_TRAILER_EN
  // The listed trailer fields total 96 bits; they are zero-extended into the low bits of the word.
  logic [DATA_WIDTH-1:0] trailer_word;
  assign trailer_word = DATA_WIDTH'({16'h0, overflow_err, 15'h0, 16'h0, words_written, 32'hF0CE_D0E5});
`endif

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (fifo_write) fifo_mem[wr_ptr] <= force_data;
  end

  // Pass sequencing, FIFO bookkeeping and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                   <= S_IDLE;
      num_lat                 <= '0;
      accepted_cnt            <= '0;
      wr_ptr                  <= '0;
      rd_ptr                  <= '0;
      fifo_cnt                <= '0;
      control_base            <= '0;
      control_length          <= '0;
      control_go              <= 1'b0;
      user_write_buffer       <= 1'b0;
      user_buffer_output_data <= '0;
      busy                    <= 1'b0;
      done                    <= 1'b0;
      overflow_err            <= 1'b0;
      words_written           <= '0;
    end else begin
      control_go        <= 1'b0;
      user_write_buffer <= 1'b0;
      done              <= 1'b0;

      if (fifo_write) wr_ptr <= wr_ptr + PTR_ONE;
      if (fifo_read)  rd_ptr <= rd_ptr + PTR_ONE;
      if (fifo_write && !fifo_read)      fifo_cnt <= fifo_cnt + FIFO_ONE;
      else if (!fifo_write && fifo_read) fifo_cnt <= fifo_cnt - FIFO_ONE;
      if (accept) accepted_cnt <= accepted_cnt + CNT_ONE;
      if (drop)   overflow_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            num_lat       <= num_particles;
            accepted_cnt  <= '0;
            words_written <= '0;
            overflow_err  <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            busy          <= 1'b1;
`ifdef FORCE_WB_TRAILER_EN
            control_go     <= 1'b1;
            control_base   <= base_addr;
            control_length <= (ADDR_WIDTH'(num_particles) + ADDR_WIDTH'(1)) * ADDR_WIDTH'(BYTES_PER_WORD);
            state          <= S_PROGRAM;
`else
            if (num_particles == '0) begin
              state <= S_DONE;
            end else begin
              control_go     <= 1'b1;
              control_base   <= base_addr;
              control_length <= ADDR_WIDTH'(num_particles) * ADDR_WIDTH'(BYTES_PER_WORD);
              state          <= S_PROGRAM;
            end
`endif
          end
        end
        S_PROGRAM: begin
          state <= S_STREAM;
        end
        S_STREAM: begin
          if (word_pop) begin
            user_write_buffer       <= 1'b1;
            user_buffer_output_data <= pop_data;
            words_written           <= words_written + CNT_ONE;
`ifndef FORCE_WB_TRAILER_EN
            if ((words_written + CNT_ONE) == num_lat) state <= S_WAIT_DONE;
`endif
          end
`ifdef FORCE_WB_TRAILER_EN
          // Quota exhausted means the FIFO is drained, so the trailer never races a force word.
          else if ((words_written == num_lat) && !user_buffer_full) begin
            user_write_buffer       <= 1'b1;
            user_buffer_output_data <= trailer_word;
            state                   <= S_WAIT_DONE;
          end
`endif
        end
        S_WAIT_DONE: begin
          if (control_done) state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_force_writeback_ctrl.sv
// Self-checking bench for force_writeback_ctrl. Force words are randomized;
// the expected write-buffer stream is simply the words sent, in order,
// truncated by the FIFO depth when the buffer is held full for a whole pass.
// Honours FORCE_WB_TRAILER_EN when defined.

module tb_force_writeback_ctrl;

  localparam int DW = 128;
  localparam int AW = 32;
  localparam int CW = 16;
`ifdef FORCE_WB_TRAILER_EN
  localparam int TRAILER = 1;
`else
  localparam int TRAILER = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_particles = '0;
  logic          force_valid = 1'b0;
  logic [DW-1:0] force_data = '0;
  logic          control_fixed_location;
  logic [AW-1:0] control_base;
  logic [AW-1:0] control_length;
  logic          control_go;
  logic          control_done = 1'b0;
  logic          user_write_buffer;
  logic [DW-1:0] user_buffer_output_data;
  logic          user_buffer_full = 1'b0;
  logic          busy;
  logic          done;
  logic          overflow_err;
  logic [CW-1:0] words_written;

  force_writeback_ctrl dut (
    .clk                     (clk),
    .rst                     (rst),
    .start                   (start),
    .base_addr               (base_addr),
    .num_particles           (num_particles),
    .force_valid             (force_valid),
    .force_data              (force_data),
    .control_fixed_location  (control_fixed_location),
    .control_base            (control_base),
    .control_length          (control_length),
    .control_go              (control_go),
    .control_done            (control_done),
    .user_write_buffer       (user_write_buffer),
    .user_buffer_output_data (user_buffer_output_data),
    .user_buffer_full        (user_buffer_full),
    .busy                    (busy),
    .done                    (done),
    .overflow_err            (overflow_err),
    .words_written           (words_written)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  int go_cnt = 0;
  int done_cnt = 0;
  logic full_at_edge = 1'b0;

  // Buffer-full level the DUT saw at the edge that produced the next outputs.
  always @(posedge clk) full_at_edge = user_buffer_full;

  // Collect write-buffer pushes and pulse counts; no push may follow a full edge.
  always @(negedge clk) begin
    if (user_write_buffer) begin
      got_q.push_back(user_buffer_output_data);
      vectors++;
      if (full_at_edge) begin
        miscompares++;
        $display("FAIL push_while_full: pushed %h with user_buffer_full=1", user_buffer_output_data);
      end
    end
    if (control_go) go_cnt++;
    if (done) done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_pass(input logic [AW-1:0] b, input logic [CW-1:0] n);
    logic [AW-1:0] exp_len;
    start = 1'b1;
    base_addr = b;
    num_particles = n;
    tick();
    start = 1'b0;
    exp_len = (AW'(n) + AW'(TRAILER)) * AW'(16);
    vectors++;
    if (control_go !== 1'b1) begin
      miscompares++;
      $display("FAIL go_after_start: control_go=%b required 1", control_go);
    end
    vectors++;
    if (control_base !== b || control_length !== exp_len) begin
      miscompares++;
      $display("FAIL program: base=%h len=%0d required base=%h len=%0d", control_base, control_length, b, exp_len);
    end
  endtask

  // full_mode: 0 never full, 1 full for the first 10 cycles, 2 random, 3 always full.
  task automatic feed(input int n, input int gap_pct, input int full_mode);
    int sent = 0;
    int cyc = 0;
    while (sent < n) begin
      force_valid = ($urandom_range(0, 99) >= gap_pct);
      if (force_valid) begin
        force_data = {32'h0, $urandom, $urandom, $urandom};
        exp_q.push_back(force_data);
        sent++;
      end
      case (full_mode)
        1:       user_buffer_full = (cyc < 10);
        2:       user_buffer_full = 1'($urandom_range(0, 1));
        3:       user_buffer_full = 1'b1;
        default: user_buffer_full = 1'b0;
      endcase
      tick();
      cyc++;
    end
    force_valid = 1'b0;
    while (full_mode == 1 && cyc < 10) begin
      user_buffer_full = 1'b1;
      tick();
      cyc++;
    end
    if (full_mode != 3) user_buffer_full = 1'b0;
  endtask

  task automatic finish_pass(input int n);
    int i;
    int d0;
    for (i = 0; i < 200 && got_q.size() < n + TRAILER; i++) tick();
    vectors++;
    if (got_q.size() != n + TRAILER) begin
      miscompares++;
      $display("FAIL push_count: got %0d pushes required %0d", got_q.size(), n + TRAILER);
    end
    for (int k = 0; k < n && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL push_data[%0d]: got %h required %h", k, got_q[k], exp_q[k]);
      end
    end
`ifdef FORCE_WB_TRAILER_EN
    if (got_q.size() == n + 1) begin
      vectors++;
      if (got_q[n][31:0] !== 32'hF0CE_D0E5 || got_q[n][47:32] !== 16'(n) || got_q[n][79] !== 1'b0) begin
        miscompares++;
        $display("FAIL trailer: got %h required magic F0CED0E5 count %0d ovf 0", got_q[n], n);
      end
    end
`endif
    vectors++;
    if (words_written !== CW'(n) || overflow_err !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_done: words_written=%0d ovf=%b busy=%b required %0d 0 1", words_written, overflow_err, busy, n);
    end
    d0 = done_cnt;
    control_done = 1'b1;
    tick();
    control_done = 1'b0;
    tick();
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: done=%b busy=%b required 1 0", done, busy);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || done_cnt != d0 + 1 || words_written !== CW'(n)) begin
      miscompares++;
      $display("FAIL done_once: done=%b pulses=%0d words_written=%0d required 0 1 %0d", done, done_cnt - d0, words_written, n);
    end
  endtask

  task automatic check_all_zero(input string name);
    vectors++;
    if ({control_fixed_location, control_go, user_write_buffer, busy, done, overflow_err} !== 6'b0 ||
        control_base !== '0 || control_length !== '0 || user_buffer_output_data !== '0 || words_written !== '0) begin
      miscompares++;
      $display("FAIL %s: outputs go=%b wb=%b busy=%b done=%b ovf=%b base=%h len=%0d ww=%0d required all 0",
               name, control_go, user_write_buffer, busy, done, overflow_err, control_base, control_length, words_written);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    check_all_zero("reset_state");
    rst = 1'b1;
    tick();
    check_all_zero("after_reset_release");
  endtask

  task automatic test_basic();
    int g0;
    got_q.delete();
    exp_q.delete();
    g0 = go_cnt;
    start_pass(32'h0000_1000, 16'd4);
    feed(4, 0, 0);
    finish_pass(4);
    vectors++;
    if (go_cnt != g0 + 1) begin
      miscompares++;
      $display("FAIL go_count_basic: got %0d go pulses required 1", go_cnt - g0);
    end
  endtask

  task automatic test_backpressure();
    got_q.delete();
    exp_q.delete();
    start_pass({$urandom_range(0, 255), 8'h00}, 16'd8);
    feed(8, 0, 1);
    finish_pass(8);
  endtask

  task automatic test_random_passes();
    for (int p = 0; p < 6; p++) begin
      int n;
      int g0;
      logic [AW-1:0] b;
      got_q.delete();
      exp_q.delete();
      n = $urandom_range(1, 16);
      b = {$urandom_range(0, 65535), 16'h0};
      g0 = go_cnt;
      start_pass(b, CW'(n));
      feed(n, 40, 2);
      start = 1'b1;
      base_addr = 32'hDEAD_0000;
      num_particles = 16'd3;
      tick();
      start = 1'b0;
      finish_pass(n);
      vectors++;
      if (go_cnt != g0 + 1 || control_base !== b) begin
        miscompares++;
        $display("FAIL start_ignored: go pulses=%0d base=%h required 1 %h", go_cnt - g0, control_base, b);
      end
    end
  endtask

  task automatic test_idle_drop();
    got_q.delete();
    for (int i = 0; i < 3; i++) begin
      force_valid = 1'b1;
      force_data = {32'h0, $urandom, $urandom, $urandom};
      tick();
    end
    force_valid = 1'b0;
    tick();
    vectors++;
    if (got_q.size() != 0 || overflow_err !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_drop: pushes=%0d ovf=%b busy=%b required 0 0 0", got_q.size(), overflow_err, busy);
    end
  endtask

  task automatic test_zero_count();
`ifndef FORCE_WB_TRAILER_EN
    int g0;
    got_q.delete();
    g0 = go_cnt;
    start = 1'b1;
    base_addr = 32'h0000_4000;
    num_particles = 16'd0;
    tick();
    start = 1'b0;
    vectors++;
    if (control_go !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_cycle1: go=%b done=%b busy=%b required 0 0 1", control_go, done, busy);
    end
    tick();
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_done: done=%b two cycles after start required 1", done);
    end
    tick();
    vectors++;
    if (go_cnt != g0 || got_q.size() != 0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_quiet: go pulses=%0d pushes=%0d done=%b required 0 0 0", go_cnt - g0, got_q.size(), done);
    end
`endif
  endtask

  task automatic test_overflow();
    int d0;
    got_q.delete();
    exp_q.delete();
    start_pass(32'h0000_2000, 16'd20);
    feed(20, 0, 3);
    tick();
    vectors++;
    if (overflow_err !== 1'b1 || got_q.size() != 0 || words_written !== 16'd0) begin
      miscompares++;
      $display("FAIL overflow_full: ovf=%b pushes=%0d ww=%0d required 1 0 0", overflow_err, got_q.size(), words_written);
    end
    user_buffer_full = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    vectors++;
    if (got_q.size() != 16 || words_written !== 16'd16 || busy !== 1'b1 || overflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_drain: pushes=%0d ww=%0d busy=%b ovf=%b required 16 16 1 1", got_q.size(), words_written, busy, overflow_err);
    end
    for (int k = 0; k < 16 && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL overflow_data[%0d]: got %h required %h", k, got_q[k], exp_q[k]);
      end
    end
    d0 = done_cnt;
    control_done = 1'b1;
    tick();
    control_done = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (done_cnt != d0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_stays_stream: done pulses=%0d busy=%b required 0 1", done_cnt - d0, busy);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset_midpass();
    int d0;
    got_q.delete();
    exp_q.delete();
    start_pass(32'h0000_3000, 16'd4);
    for (int i = 0; i < 4 && got_q.size() < 2; i++) begin
      force_valid = 1'b1;
      force_data = {32'h0, $urandom, $urandom, $urandom};
      exp_q.push_back(force_data);
      tick();
    end
    for (int i = 0; i < 10 && got_q.size() < 2; i++) begin
      force_valid = 1'b0;
      tick();
    end
    force_valid = 1'b0;
    vectors++;
    if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      miscompares++;
      $display("FAIL midpass_pushes: got %0d pushes required 2 matching words", got_q.size());
    end
    d0 = done_cnt;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done: done pulses=%0d busy=%b required 0 0", done_cnt - d0, busy);
    end
    got_q.delete();
    exp_q.delete();
    start_pass(32'h0000_5000, 16'd4);
    feed(4, 20, 0);
    finish_pass(4);
  endtask

  task automatic test_trailer();
`ifdef FORCE_WB_TRAILER_EN
    got_q.delete();
    exp_q.delete();
    start_pass(32'h0000_6000, 16'd2);
    vectors++;
    if (control_length !== 32'd48) begin
      miscompares++;
      $display("FAIL trailer_length: got %0d required 48", control_length);
    end
    feed(2, 0, 0);
    finish_pass(2);
    got_q.delete();
    exp_q.delete();
    start_pass(32'h0000_7000, 16'd0);
    finish_pass(0);
`endif
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_idle_drop();
    test_backpressure();
    test_random_passes();
    test_zero_count();
    test_overflow();
    test_reset_midpass();
    test_trailer();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
